// File: rtl/stream_demux_32_if.sv
// Handshake bundle for stream_demux_32: one input stream with select, two output streams.
// The master modport is the environment side, the slave modport is the demux side.
interface stream_demux_32_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             s0;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    modport master (
        output in_valid, in_data, s0, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport slave (
        input  in_valid, in_data, s0, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/stream_demux_32.sv
// Registered 1-to-2 stream demultiplexer; each output owns a one-entry holding slot.
// Optional per-output transfer counters when DEMUX_STATS_EN is defined.
//
// state | meaning
// EMPTY | slot holds no word, outN_valid=0
// FULL  | slot holds a word, outN_valid=1
module stream_demux_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic reset,
    stream_demux_32_if.slave bus
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e            st0_q, st0_d;
    slot_e            st1_q, st1_d;
    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic             can0, can1;
    logic             acc0, acc1;

    // A full slot can still load when its consumer drains it this cycle.
    assign can0 = (st0_q == EMPTY) || bus.out0_ready;
    assign can1 = (st1_q == EMPTY) || bus.out1_ready;

    assign bus.in_ready = bus.s0 ? can1 : can0;

    assign acc0 = bus.in_valid && can0 && !bus.s0;
    assign acc1 = bus.in_valid && can1 &&  bus.s0;

    always_comb begin
        st0_d   = st0_q;
        data0_d = data0_q;
        if (acc0) begin
            st0_d   = FULL;
            data0_d = bus.in_data;
        end else if ((st0_q == FULL) && bus.out0_ready) begin
            st0_d   = EMPTY;
        end
    end

    always_comb begin
        st1_d   = st1_q;
        data1_d = data1_q;
        if (acc1) begin
            st1_d   = FULL;
            data1_d = bus.in_data;
        end else if ((st1_q == FULL) && bus.out1_ready) begin
            st1_d   = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st0_q   <= EMPTY;
            st1_q   <= EMPTY;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            st0_q   <= st0_d;
            st1_q   <= st1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    assign bus.out0_valid = (st0_q == FULL);
    assign bus.out1_valid = (st1_q == FULL);
    assign bus.out0_data  = data0_q;
    assign bus.out1_data  = data1_q;

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Counters wrap naturally at 2^CNT_W.
    always_comb begin
        cnt0_d = cnt0_q + CNT_W'(bus.out0_valid && bus.out0_ready);
        cnt1_d = cnt1_q + CNT_W'(bus.out1_valid && bus.out1_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign count0 = cnt0_q;
    assign count1 = cnt1_q;
`endif

endmodule

// File: tb/tb_stream_demux_32.sv
// Scoreboard bench for stream_demux_32: expected words queued on accept, checked on drain.
// Optional counter checks when DEMUX_STATS_EN is defined.
module tb_stream_demux_32;

`ifdef DEMUX_STATS_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_acc = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    stream_demux_32_if #(.WIDTH(32)) bus ();

`ifdef DEMUX_STATS_EN
    logic [CW-1:0] count0, count1;
`endif

    stream_demux_32 #(.WIDTH(32), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DEMUX_STATS_EN
        ,
        .count0(count0),
        .count1(count1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called just after a negedge with inputs already driven; checks this cycle, then advances one cycle.
    task automatic step();
        logic exp_rdy;
        #1;
        exp_rdy = bus.s0 ? (q1.size() == 0 || bus.out1_ready) : (q0.size() == 0 || bus.out0_ready);
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
        chk("out0_valid", {31'b0, bus.out0_valid}, {31'b0, q0.size() != 0});
        chk("out1_valid", {31'b0, bus.out1_valid}, {31'b0, q1.size() != 0});
        if (q0.size() != 0) chk("out0_data", bus.out0_data, q0[0]);
        if (q1.size() != 0) chk("out1_data", bus.out1_data, q1[0]);
        if (q0.size() != 0 && bus.out0_ready) void'(q0.pop_front());
        if (q1.size() != 0 && bus.out1_ready) void'(q1.pop_front());
        if (bus.in_valid && exp_rdy) begin
            n_acc++;
            if (bus.s0) q1.push_back(bus.in_data);
            else        q0.push_back(bus.in_data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic r0, input logic r1);
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.s0         = s;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_out0_valid", {31'b0, bus.out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'b0, bus.out1_valid}, 32'd0);
        chk("rst_out0_data", bus.out0_data, 32'h0);
        chk("rst_out1_data", bus.out1_data, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // single word to out1, visible exactly one cycle
        drive(1'b1, 32'h0000007F, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step();
        step();
        chk("t1_drained", q1.size(), 0);

        // stalled out0 back-pressures a second word to the same slot
        drive(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("t2_held", bus.out0_data, 32'hA5A5A5A5);
        drive(1'b1, 32'h00000001, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        chk("t2_drained", q0.size(), 0);

        // stalled out0 does not block traffic to out1
        drive(1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h12345678, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step();
        chk("t3_out0_kept", bus.out0_data, 32'hCAFEF00D);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step();
        step();

        // streaming 1..8 alternating, one accept per cycle
        n_acc = 0;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i, ~i[0], 1'b1, 1'b1);
            step();
        end
        chk("t4_accepts", n_acc, 8);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step();
        step();
        chk("t4_q0_empty", q0.size(), 0);
        chk("t4_q1_empty", q1.size(), 0);

        // asynchronous reset with both slots full
        drive(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h22222222, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t5_pre0", {31'b0, bus.out0_valid}, 32'd1);
        chk("t5_pre1", {31'b0, bus.out1_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_v0", {31'b0, bus.out0_valid}, 32'd0);
        chk("t5_v1", {31'b0, bus.out1_valid}, 32'd0);
        chk("t5_d0", bus.out0_data, 32'h0);
        chk("t5_d1", bus.out1_data, 32'h0);
        chk("t5_rdy", {31'b0, bus.in_ready}, 32'd1);
        q0.delete();
        q1.delete();
        @(negedge clk);
        reset = 1'b0;
        step();

`ifdef DEMUX_STATS_EN
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h100 + i, 1'b0, 1'b1, 1'b1);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step();
        step();
        chk("count0_wrap", {28'b0, count0}, 32'd1);
        chk("count1_zero", {28'b0, count1}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stream_demux_32.md
# stream_demux_32

- Registered 1-to-2 demultiplexer with valid/ready handshakes on all sides.
- Receives one 32-bit word stream and steers each word, by a per-word select bit, to one of two downstream consumers.
- Is the counterpart of the 2:1 32-bit select mux: it splits one result bus across two destinations, e.g. register write-back path versus data-memory path.
- Each output has a one-entry holding register, so a stalled consumer never blocks traffic bound for the other output.

## Interface
- WIDTH, 32, data width of input and both outputs
- CNT_W, 16, width of per-output transfer counters (used only with DEMUX_STATS_EN)

- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- in_valid  input  1  in_data/s0 valid
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  word to steer
- s0  input  1  destination select: 0 -> out0, 1 -> out1; sampled only on acceptance
- out0_valid  output  1  out0_data holds a word
- out0_ready  input  1  consumer 0 takes the word
- out0_data  output  WIDTH  word for destination 0
- out1_valid  output  1  out1_data holds a word
- out1_ready  input  1  consumer 1 takes the word
- out1_data  output  WIDTH  word for destination 1
- count0, count1  output  CNT_W  completed transfers per output (only with DEMUX_STATS_EN)

## Operation
- Each output slot is a 2-state FSM: EMPTY (outN_valid=0) or FULL (outN_valid=1).
- Slot N can load when it is EMPTY, or FULL with outN_ready=1 (drain and refill in the same cycle).
- in_ready = can-load of the slot addressed by the current s0. It is combinational from s0, outN_valid and outN_ready. It is not a function of in_valid.
- Accept = in_valid & in_ready. On accept, in_data is registered into slot s0 and that slot is FULL next cycle.
- Transitions per slot:
  - EMPTY -> FULL on accept into it.
  - FULL -> EMPTY on outN_ready with no accept into it.
  - FULL -> FULL (new data) on outN_ready plus accept into it.
  - FULL -> FULL (hold) on !outN_ready.
- While FULL and not ready, outN_data is stable and does not change.
- The unselected slot is never written; its data and valid are unaffected by input traffic.
- Ordering: words to the same output leave in input order. Words to different outputs may complete in any relative order.
- No data transformation; full WIDTH passes unmodified.

## Timing
- Latency: 1 cycle. A word accepted at edge k is visible on outN_data/outN_valid after edge k.
- Throughput: 1 word/cycle per output while its consumer holds ready=1.
- Reset (asynchronous, any time, including mid-transfer):
  - out0_valid and out1_valid = 0.
  - out0_data and out1_data = 0.
  - count0 and count1 = 0.
  - Held words are discarded.
  - in_ready reflects empty slots (=1) while reset is asserted and after release.
- The first accept is possible on the first rising edge after reset deasserts.
- in_valid with the addressed slot FULL and not ready: in_ready=0, nothing is captured, and the producer must hold in_data/s0.
- Simultaneous accept into slot 0 and drain of slot 1 (or the reverse) is legal in one cycle.

## Configuration
- DEMUX_STATS_EN defined:
  - Ports count0/count1 exist.
  - countN increments by 1 on each outN_valid & outN_ready cycle.
  - Counters wrap from 2^CNT_W-1 to 0.
  - Counters are reset asynchronously to 0.
- DEMUX_STATS_EN undefined:
  - Counter ports and logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then in_data=0x0000007F, s0=1, in_valid=1 for one cycle, out1_ready=1 -> out1_valid=1 with out1_data=0x0000007F for exactly one cycle; out0_valid stays 0.
- Hold out0_ready=0, send 0xA5A5A5A5 with s0=0, then 0x00000001 with s0=0 -> in_ready=0 on the second word; out0_data stays 0xA5A5A5A5 until out0_ready=1; the second word appears the following cycle.
- Stall out0 (full), then send 0x12345678 with s0=1 and out1_ready=1 -> accepted immediately, out1_data=0x12345678 one cycle later; out0 is unchanged.
- Both readies held at 1, stream words 1..8 alternating s0 -> one accept per cycle, no gaps; odd-indexed words appear on out0 in order, even-indexed words on out1 in order.
- Assert reset while both slots are FULL -> both valids drop to 0 asynchronously (before the next edge) and both data outputs read 0.
- With DEMUX_STATS_EN and CNT_W=4, perform 17 transfers to out0 -> count0=1 (wrapped) and count1=0.
